// File: rtl/ats21_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : ats21_cmd_issuer
//  Purpose  : Two-client command front-end for the ATS21 timer block. Each
//             client's instructions are queued, then issued as a two-beat
//             req transfer with the ATS21 status returned as a per-client
//             ack/nack.
//  Revision : 1.0  initial release
// ============================================================================
module ats21_cmd_issuer #(
  parameter int DEPTH    = 4,
  parameter int STAT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_instr,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_instr,
  output logic        req,
  output logic [15:0] ctrlA,
  output logic [15:0] ctrlB,
  input  logic [1:0]  stat,
  output logic        resp_a_valid,
  output logic        resp_a_ack,
  output logic        resp_b_valid,
  output logic        resp_b_ack,
  output logic        busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(STAT_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          w_push_valid;
  logic [1:0][31:0]    w_push_data;
  logic [1:0]          w_fifo_ready;
  logic [1:0]          w_fifo_nonempty;
  logic [1:0]          w_pop;
  logic [1:0][31:0]    w_head;

  logic [31:0]         r_inst_a;
  logic [31:0]         r_inst_b;
  logic                r_pa;
  logic                r_pb;
  logic [c_CNT_W-1:0]  r_wait_cnt;
  logic                r_resp_a_valid;
  logic                r_resp_a_ack;
  logic                r_resp_b_valid;
  logic                r_resp_b_ack;

  logic                w_req;
  logic [15:0]         w_ctrl_a;
  logic [15:0]         w_ctrl_b;
  logic                w_stat_capture;
  logic                w_nop_a;
  logic                w_nop_b;

  assign w_push_valid   = {b_valid, a_valid};
  assign w_push_data[0] = a_instr;
  assign w_push_data[1] = b_instr;

  // Index 0 is client A, index 1 is client B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [31:0]      r_mem [DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [PTR_W:0]   r_count;
      logic             w_push;

      assign w_fifo_ready[gi]    = (r_count != (PTR_W+1)'(DEPTH));
      assign w_fifo_nonempty[gi] = (r_count != '0);
      assign w_push              = w_push_valid[gi] && w_fifo_ready[gi];
      assign w_head[gi]          = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data[gi];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          case ({w_push, w_pop[gi]})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  assign a_ready = w_fifo_ready[0];
  assign b_ready = w_fifo_ready[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bus outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 2'b00;
    w_req          = 1'b0;
    w_ctrl_a       = 16'h0000;
    w_ctrl_b       = 16'h0000;
    w_stat_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_fifo_nonempty) begin
          w_pop       = w_fifo_nonempty;
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        w_req       = 1'b1;
        w_ctrl_a    = r_pa ? r_inst_a[31:16] : 16'h0000;
        w_ctrl_b    = r_pb ? r_inst_b[31:16] : 16'h0000;
        w_state_nxt = S_LO;
      end
      S_LO: begin
        w_req       = 1'b1;
        w_ctrl_a    = r_pa ? r_inst_a[15:0] : 16'h0000;
        w_ctrl_b    = r_pb ? r_inst_b[15:0] : 16'h0000;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == c_CNT_W'(1)) begin
          w_stat_capture = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Opcode 000 is a nop; the ATS21 sees an idle upper half and we always ack it.
  assign w_nop_a = (r_inst_a[31:29] == 3'b000);
  assign w_nop_b = (r_inst_b[31:29] == 3'b000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst_a       <= '0;
      r_inst_b       <= '0;
      r_pa           <= 1'b0;
      r_pb           <= 1'b0;
      r_wait_cnt     <= '0;
      r_resp_a_valid <= 1'b0;
      r_resp_a_ack   <= 1'b0;
      r_resp_b_valid <= 1'b0;
      r_resp_b_ack   <= 1'b0;
    end else begin
      if (|w_pop) begin
        r_pa     <= w_pop[0];
        r_pb     <= w_pop[1];
        r_inst_a <= w_pop[0] ? w_head[0] : 32'h0;
        r_inst_b <= w_pop[1] ? w_head[1] : 32'h0;
      end
      if (r_state == S_LO)        r_wait_cnt <= c_CNT_W'(STAT_LAT);
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt - c_CNT_W'(1);
      r_resp_a_valid <= w_stat_capture && r_pa;
      r_resp_a_ack   <= w_stat_capture && r_pa && (w_nop_a || stat[0]);
      r_resp_b_valid <= w_stat_capture && r_pb;
      r_resp_b_ack   <= w_stat_capture && r_pb && (w_nop_b || stat[1]);
    end
  end

  assign req          = w_req;
  assign ctrlA        = w_ctrl_a;
  assign ctrlB        = w_ctrl_b;
  assign resp_a_valid = r_resp_a_valid;
  assign resp_a_ack   = r_resp_a_ack;
  assign resp_b_valid = r_resp_b_valid;
  assign resp_b_ack   = r_resp_b_ack;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ats21_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ats21_cmd_issuer
//  Purpose  : Directed self-checking bench for ats21_cmd_issuer (STAT_LAT 1 and 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ats21_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_instr = '0, b_instr = '0;
  logic        a_ready, b_ready, req, busy;
  logic [15:0] ctrlA, ctrlB;
  logic [1:0]  stat = 2'b00;
  logic        resp_a_valid, resp_a_ack, resp_b_valid, resp_b_ack;

  // Second instance with a longer status latency.
  logic        a_valid3 = 1'b0, b_valid3 = 1'b0;
  logic [31:0] a_instr3 = '0, b_instr3 = '0;
  logic        a_ready3, b_ready3, req3, busy3;
  logic [15:0] ctrlA3, ctrlB3;
  logic [1:0]  stat3 = 2'b00;
  logic        resp_a_valid3, resp_a_ack3, resp_b_valid3, resp_b_ack3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] beats[$];

  always #5 clk = ~clk;

  ats21_cmd_issuer #(.DEPTH(4), .STAT_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_instr(a_instr),
    .b_valid(b_valid), .b_ready(b_ready), .b_instr(b_instr),
    .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .stat(stat),
    .resp_a_valid(resp_a_valid), .resp_a_ack(resp_a_ack),
    .resp_b_valid(resp_b_valid), .resp_b_ack(resp_b_ack), .busy(busy)
  );

  ats21_cmd_issuer #(.DEPTH(4), .STAT_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid3), .a_ready(a_ready3), .a_instr(a_instr3),
    .b_valid(b_valid3), .b_ready(b_ready3), .b_instr(b_instr3),
    .req(req3), .ctrlA(ctrlA3), .ctrlB(ctrlB3), .stat(stat3),
    .resp_a_valid(resp_a_valid3), .resp_a_ack(resp_a_ack3),
    .resp_b_valid(resp_b_valid3), .resp_b_ack(resp_b_ack3), .busy(busy3)
  );

  always @(negedge clk) if (req) beats.push_back(ctrlA);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++; if (req !== 1'b0) $display("FAIL rst_req got=%0b exp=0", req); else n_pass++;
    n_checks++; if (ctrlA !== 16'h0 || ctrlB !== 16'h0) $display("FAIL rst_ctrl got=%h/%h exp=0000/0000", ctrlA, ctrlB); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (resp_a_valid !== 1'b0 || resp_b_valid !== 1'b0) $display("FAIL rst_resp got=%0b%0b exp=00", resp_a_valid, resp_b_valid); else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL rst_ready got=%0b%0b exp=11", a_ready, b_ready); else n_pass++;
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_instr = 32'h2A40_1234;
    tick();
    a_valid = 1'b0;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'h2A40 || ctrlB !== 16'h0) $display("FAIL single_hi got=%0b %h %h exp=1 2a40 0000", req, ctrlA, ctrlB); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%0b exp=1", busy); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'h1234 || ctrlB !== 16'h0) $display("FAIL single_lo got=%0b %h %h exp=1 1234 0000", req, ctrlA, ctrlB); else n_pass++;
    stat = 2'b01;
    tick();
    n_checks++; if (req !== 1'b0 || ctrlA !== 16'h0 || resp_a_valid !== 1'b0) $display("FAIL single_wait got=%0b %h %0b exp=0 0000 0", req, ctrlA, resp_a_valid); else n_pass++;
    tick();
    stat = 2'b00;
    n_checks++; if (resp_a_valid !== 1'b1 || resp_a_ack !== 1'b1) $display("FAIL single_resp got=%0b/%0b exp=1/1", resp_a_valid, resp_a_ack); else n_pass++;
    n_checks++; if (resp_b_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_bidle got=%0b/%0b exp=0/0", resp_b_valid, busy); else n_pass++;
    tick();
    n_checks++; if (resp_a_valid !== 1'b0) $display("FAIL single_pulse got=%0b exp=0", resp_a_valid); else n_pass++;
  endtask

  task automatic test_paired();
    a_valid = 1'b1; a_instr = 32'hA012_0064;
    b_valid = 1'b1; b_instr = 32'hC180_0000;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'hA012 || ctrlB !== 16'hC180) $display("FAIL pair_hi got=%0b %h %h exp=1 a012 c180", req, ctrlA, ctrlB); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'h0064 || ctrlB !== 16'h0000) $display("FAIL pair_lo got=%0b %h %h exp=1 0064 0000", req, ctrlA, ctrlB); else n_pass++;
    stat = 2'b10;
    tick();
    tick();
    stat = 2'b00;
    n_checks++; if (resp_a_valid !== 1'b1 || resp_a_ack !== 1'b0) $display("FAIL pair_resp_a got=%0b/%0b exp=1/0", resp_a_valid, resp_a_ack); else n_pass++;
    n_checks++; if (resp_b_valid !== 1'b1 || resp_b_ack !== 1'b1) $display("FAIL pair_resp_b got=%0b/%0b exp=1/1", resp_b_valid, resp_b_ack); else n_pass++;
    tick();
  endtask

  task automatic test_nop();
    a_valid = 1'b1; a_instr = 32'h0000_0000;
    tick();
    a_valid = 1'b0;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'h0 || ctrlB !== 16'h0) $display("FAIL nop_hi got=%0b %h %h exp=1 0000 0000", req, ctrlA, ctrlB); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'h0) $display("FAIL nop_lo got=%0b %h exp=1 0000", req, ctrlA); else n_pass++;
    stat = 2'b00;
    tick();
    tick();
    n_checks++; if (resp_a_valid !== 1'b1 || resp_a_ack !== 1'b1) $display("FAIL nop_resp got=%0b/%0b exp=1/1", resp_a_valid, resp_a_ack); else n_pass++;
    tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] v [6];
    int guard;
    v[0] = 32'h2111_0001; v[1] = 32'h4222_0002; v[2] = 32'h6333_0003;
    v[3] = 32'h8444_0004; v[4] = 32'hA555_0005; v[5] = 32'hC666_0006;
    beats.delete();
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_instr = v[i];
      if (i == 5) begin
        n_checks++; if (a_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", a_ready); else n_pass++;
      end
      guard = 0;
      while (a_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
      tick();
    end
    a_valid = 1'b0;
    guard = 0;
    while (beats.size() < 12 && guard < 200) begin tick(); guard++; end
    n_checks++; if (beats.size() < 12) $display("FAIL full_timeout got=%0d beats exp=12", beats.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] got;
      got = (beats.size() >= 2*i+2) ? {beats[2*i], beats[2*i+1]} : 32'hxxxx_xxxx;
      n_checks++; if (got !== v[i]) $display("FAIL full_order%0d got=%h exp=%h", i, got, v[i]); else n_pass++;
    end
    repeat (4) tick();
    n_checks++; if (a_ready !== 1'b1 || busy !== 1'b0) $display("FAIL full_drain got=%0b/%0b exp=1/0", a_ready, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic seen_req, seen_resp;
    a_valid = 1'b1; a_instr = 32'h2A40_1234;
    tick();
    a_instr = 32'h3B50_5678;
    tick();
    a_valid = 1'b0;
    tick();
    n_checks++; if (req !== 1'b1 || ctrlA !== 16'h1234) $display("FAIL mid_lo got=%0b %h exp=1 1234", req, ctrlA); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (req !== 1'b0 || ctrlA !== 16'h0 || ctrlB !== 16'h0) $display("FAIL mid_async got=%0b %h %h exp=0 0000 0000", req, ctrlA, ctrlB); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%0b exp=0", busy); else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (a_ready !== 1'b1) $display("FAIL mid_ready got=%0b exp=1", a_ready); else n_pass++;
    seen_req = 1'b0; seen_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_req  = seen_req | req;
      seen_resp = seen_resp | resp_a_valid | resp_b_valid;
      tick();
    end
    n_checks++; if (seen_req !== 1'b0) $display("FAIL mid_flush got=%0b exp=0", seen_req); else n_pass++;
    n_checks++; if (seen_resp !== 1'b0) $display("FAIL mid_noresp got=%0b exp=0", seen_resp); else n_pass++;
  endtask

  // Run twice: once with the correct sample cycle carrying Nack, once carrying Ack.
  task automatic test_stat_lat3(input logic good_bit);
    a_valid3 = 1'b1; a_instr3 = 32'h2A40_1234;
    tick();
    a_valid3 = 1'b0;
    tick();
    n_checks++; if (req3 !== 1'b1 || ctrlA3 !== 16'h2A40) $display("FAIL lat3_hi got=%0b %h exp=1 2a40", req3, ctrlA3); else n_pass++;
    tick();
    n_checks++; if (req3 !== 1'b1 || ctrlA3 !== 16'h1234 || ctrlB3 !== 16'h0) $display("FAIL lat3_lo got=%0b %h %h exp=1 1234 0000", req3, ctrlA3, ctrlB3); else n_pass++;
    tick();
    tick();
    stat3 = {1'b0, ~good_bit};
    tick();
    stat3 = {1'b0, good_bit};
    n_checks++; if (resp_a_valid3 !== 1'b0 || busy3 !== 1'b1) $display("FAIL lat3_early got=%0b/%0b exp=0/1", resp_a_valid3, busy3); else n_pass++;
    tick();
    stat3 = {1'b0, ~good_bit};
    n_checks++; if (resp_a_valid3 !== 1'b1 || resp_a_ack3 !== good_bit) $display("FAIL lat3_resp got=%0b/%0b exp=1/%0b", resp_a_valid3, resp_a_ack3, good_bit); else n_pass++;
    n_checks++; if (resp_b_valid3 !== 1'b0) $display("FAIL lat3_b got=%0b exp=0", resp_b_valid3); else n_pass++;
    tick();
    stat3 = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_paired();
    test_nop();
    test_fifo_full();
    test_reset_mid_op();
    test_stat_lat3(1'b0);
    test_stat_lat3(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
